// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the XADC DRP sequencer: FSM states,
// auxiliary channel address table and the channel-pick helper.
package adc_seq_pkg;

    localparam int unsigned DRP_DW = 16;
    localparam int unsigned MAX_CH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } seq_state_t;

    localparam logic [6:0] CH_ADDR [MAX_CH] = '{7'h1f, 7'h1e, 7'h17, 7'h16};

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] pick_ch(input logic [MAX_CH-1:0] mask,
                                           input logic [2:0]        from);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (!r[2] && (i >= 32'(from)) && mask[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sweep-rate tick: one-cycle pulse every CLOCK_FREQ/SAMPLING_FREQ cycles,
// counter held at zero while disabled.
module sample_tick_gen #(
    parameter int unsigned CLOCK_FREQ    = 100_000_000,
    parameter int unsigned SAMPLING_FREQ = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned TICK_DIV = CLOCK_FREQ / SAMPLING_FREQ;
    localparam int unsigned CNT_W    = $clog2(TICK_DIV);

    if (TICK_DIV < 2) begin : g_div_check
        $error("sample_tick_gen: CLOCK_FREQ/SAMPLING_FREQ must be at least 2");
    end

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
        end else if (count == CNT_W'(TICK_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Periodic XADC DRP read sequencer: sweeps the masked aux channels each tick.
// Optional DRP ready timeout enabled by defining XADC_SEQ_TIMEOUT_EN.
module xadc_drp_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CLOCK_FREQ     = 100_000_000,
    parameter int unsigned SAMPLING_FREQ  = 2000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic              den_out,
    output logic              dwe_out,
    output logic [DRP_DW-1:0] di_out,
    output logic [6:0]        daddr_out,
    input  logic              drdy_in,
    input  logic [DRP_DW-1:0] do_in,
    output logic              sample_valid,
    output logic [DRP_DW-1:0] sample_data,
    output logic [1:0]        sample_chan,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("xadc_drp_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_t        state, state_d;
    logic              tick;
    logic [MAX_CH-1:0] mask_in, mask_q;
    logic [1:0]        cur_q;
    logic [2:0]        pick;
    logic              load_ch, capture;
`ifdef XADC_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
    logic [WAIT_W-1:0] wait_cnt;
    logic              expire;
`endif

    assign mask_in = MAX_CH'(chan_mask);

    sample_tick_gen #(
        .CLOCK_FREQ    (CLOCK_FREQ),
        .SAMPLING_FREQ (SAMPLING_FREQ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        load_ch = 1'b0;
        capture = 1'b0;
        pick    = '0;
`ifdef XADC_SEQ_TIMEOUT_EN
        expire  = 1'b0;
`endif
        case (state)
            IDLE: begin
                pick = pick_ch(mask_in, 3'd0);
                if (tick && en && pick[2]) begin
                    load_ch = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Ready takes priority over an expiring timeout in the same cycle.
                if (drdy_in) begin
                    capture = 1'b1;
                    state_d = NEXT;
                end
`ifdef XADC_SEQ_TIMEOUT_EN
                else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    expire  = 1'b1;
                    state_d = NEXT;
                end
`endif
            end
            NEXT: begin
                pick = pick_ch(mask_q, {1'b0, cur_q} + 3'd1);
                if (en && pick[2]) begin
                    load_ch = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= '0;
            cur_q        <= '0;
            daddr_out    <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_chan  <= '0;
        end else begin
            sample_valid <= capture;
            if (load_ch) begin
                cur_q     <= pick[1:0];
                daddr_out <= CH_ADDR[pick[1:0]];
            end
            // The mask is frozen for the whole sweep; only a fresh start reloads it.
            if (load_ch && (state == IDLE)) begin
                mask_q <= mask_in;
            end
            if (capture) begin
                sample_data <= do_in;
                sample_chan <= cur_q;
            end
        end
    end

`ifdef XADC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || (state != WAIT)) wait_cnt <= '0;
        else                          wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= expire;
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign den_out = (state == ISSUE);
    assign dwe_out = 1'b0;
    assign di_out  = '0;
    assign busy    = (state != IDLE);
    assign overrun = tick && busy;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: per-cycle vector table for the
// single-channel and two-channel sweeps, hand sequences for the corner cases.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  chan_mask;
    logic        den_out, dwe_out;
    logic [15:0] di_out;
    logic [6:0]  daddr_out;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [1:0]  sample_chan;
    logic        busy, overrun, timeout_err;

    logic        man_drdy;
    logic [15:0] man_do;
    logic        mod_drdy = 1'b0;
    logic        model_on = 1'b0;
    int          model_lat = 0;
    logic [15:0] model_data = '0;
    int          m_cnt = 0;

    assign drdy_in = man_drdy | mod_drdy;
    assign do_in   = man_drdy ? man_do : model_data;

    always #5 clk = ~clk;

    xadc_drp_sequencer #(
        .NUM_CH         (4),
        .CLOCK_FREQ     (1000),
        .SAMPLING_FREQ  (100),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .chan_mask    (chan_mask),
        .den_out      (den_out),
        .dwe_out      (dwe_out),
        .di_out       (di_out),
        .daddr_out    (daddr_out),
        .drdy_in      (drdy_in),
        .do_in        (do_in),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_chan  (sample_chan),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DRP responder: ready pulse model_lat cycles after each den.
    always @(negedge clk) begin
        mod_drdy = 1'b0;
        if (!model_on) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) mod_drdy = 1'b1;
            end
            if (den_out) m_cnt = model_lat;
        end
    end

    int         den_t[$], sv_t[$], ovr_t[$], to_t[$];
    logic [6:0] den_a[$];
    logic [1:0] sv_c[$];
    logic [15:0] sv_d[$];

    always @(negedge clk) begin
        if (den_out) begin
            den_t.push_back(cyc);
            den_a.push_back(daddr_out);
        end
        if (sample_valid) begin
            sv_t.push_back(cyc);
            sv_c.push_back(sample_chan);
            sv_d.push_back(sample_data);
        end
        if (overrun)     ovr_t.push_back(cyc);
        if (timeout_err) to_t.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;
    int base = 0;
    int n_den = 0, n_sv = 0, n_ovr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cnt_in(input int q[$], input int b, input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if ((q[i] - b >= lo) && (q[i] - b <= hi)) n++;
        return n;
    endfunction

    function automatic int at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic do_reset();
        model_on  = 1'b0;
        man_drdy  = 1'b0;
        man_do    = '0;
        en        = 1'b0;
        chan_mask = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] m, input logic mon, input int lat,
                             input logic [15:0] d);
        do_reset();
        model_lat  = lat;
        model_data = d;
        model_on   = mon;
        @(posedge clk);
        #1;
        en        = 1'b1;
        chan_mask = m;
        base      = cyc;
        n_den     = den_t.size();
        n_sv      = sv_t.size();
        n_ovr     = ovr_t.size();
    endtask

    task automatic goto(input int rel);
        do @(negedge clk); while (cyc - base < rel);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " den_out"}, den_out, 0);
        chk({tag, " dwe_out"}, dwe_out, 0);
        chk({tag, " di_out"}, di_out, 0);
        chk({tag, " daddr_out"}, daddr_out, 0);
        chk({tag, " sample_valid"}, sample_valid, 0);
        chk({tag, " sample_data"}, sample_data, 0);
        chk({tag, " sample_chan"}, sample_chan, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " overrun"}, overrun, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic        drdy;
        logic [15:0] dat;
        logic        den;
        logic [6:0]  addr;
        logic        sv;
        logic [15:0] sdata;
        logic [1:0]  schan;
        logic        busy;
        logic        ovr;
    } vec_t;

    localparam int NROW = 42;
    vec_t vt [NROW];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // TICK_DIV = 10: ticks at rows 9, 19, 29, 39; DRP answers 3 cycles after den.
        for (int i = 0; i < NROW; i++) begin
            vt[i].en    = 1'b1;
            vt[i].mask  = (i < 25) ? 4'b0001 : (i < 32) ? 4'b1010 : 4'b0001;
            vt[i].drdy  = 1'b0;
            vt[i].dat   = '0;
            vt[i].den   = 1'b0;
            vt[i].addr  = (i < 10) ? 7'h00 : (i < 30) ? 7'h1f : (i < 35) ? 7'h1e : 7'h16;
            vt[i].sv    = 1'b0;
            vt[i].sdata = '0;
            vt[i].schan = '0;
            vt[i].busy  = (i >= 10 && i <= 14) || (i >= 20 && i <= 24) || (i >= 30 && i <= 39);
            vt[i].ovr   = 1'b0;
        end
        vt[10].den = 1'b1;
        vt[20].den = 1'b1;
        vt[30].den = 1'b1;
        vt[35].den = 1'b1;
        vt[13].drdy = 1'b1; vt[13].dat = 16'hABC0;
        vt[23].drdy = 1'b1; vt[23].dat = 16'hABC0;
        vt[33].drdy = 1'b1; vt[33].dat = 16'h1234;
        vt[38].drdy = 1'b1; vt[38].dat = 16'h5678;
        vt[14].sv = 1'b1; vt[14].sdata = 16'hABC0; vt[14].schan = 2'd0;
        vt[24].sv = 1'b1; vt[24].sdata = 16'hABC0; vt[24].schan = 2'd0;
        vt[34].sv = 1'b1; vt[34].sdata = 16'h1234; vt[34].schan = 2'd1;
        vt[39].sv = 1'b1; vt[39].sdata = 16'h5678; vt[39].schan = 2'd3;
        vt[39].ovr = 1'b1;

        do_reset();
        @(negedge clk);
        chk_all_zero("reset");

        for (int k = 0; k < NROW; k++) begin
            @(posedge clk);
            #1;
            en        = vt[k].en;
            chan_mask = vt[k].mask;
            man_drdy  = vt[k].drdy;
            man_do    = vt[k].dat;
            @(negedge clk);
            chk($sformatf("row%0d den_out", k), den_out, vt[k].den);
            chk($sformatf("row%0d daddr_out", k), daddr_out, vt[k].addr);
            chk($sformatf("row%0d busy", k), busy, vt[k].busy);
            chk($sformatf("row%0d sample_valid", k), sample_valid, vt[k].sv);
            chk($sformatf("row%0d overrun", k), overrun, vt[k].ovr);
            chk($sformatf("row%0d timeout_err", k), timeout_err, 0);
            if (vt[k].sv) begin
                chk($sformatf("row%0d sample_data", k), sample_data, vt[k].sdata);
                chk($sformatf("row%0d sample_chan", k), sample_chan, vt[k].schan);
            end
        end

        // Overrun: 15-cycle DRP latency against a 10-cycle tick period.
        start_run(4'b0001, 1'b1, 15, 16'h0F00);
        goto(55);
        chk("ovr den count", cnt_in(den_t, base, 0, 55), 3);
        chk("ovr den t0", at(den_t, n_den) - base, 10);
        chk("ovr den t1", at(den_t, n_den + 1) - base, 30);
        chk("ovr den t2", at(den_t, n_den + 2) - base, 50);
        chk("ovr pulse count", cnt_in(ovr_t, base, 0, 55), 2);
        chk("ovr pulse t0", at(ovr_t, n_ovr) - base, 19);
        chk("ovr pulse t1", at(ovr_t, n_ovr + 1) - base, 39);
        chk("ovr sample count", cnt_in(sv_t, base, 0, 55), 2);
        chk("ovr sample t0", at(sv_t, n_sv) - base, 26);
        chk("ovr sample t1", at(sv_t, n_sv + 1) - base, 46);
        if (sv_d.size() > n_sv) chk("ovr sample data", sv_d[n_sv], 16'h0F00);
        else                    chk("ovr sample data present", 0, 1);

        // en dropped while channel 1 of a four-channel sweep is in WAIT.
        start_run(4'b1111, 1'b1, 3, 16'h1110);
        goto(16);
        en = 1'b0;
        goto(19);
        chk("endrop busy in NEXT", busy, 1);
        chk("endrop sample_valid", sample_valid, 1);
        chk("endrop sample_chan", sample_chan, 1);
        chk("endrop sample_data", sample_data, 16'h1110);
        goto(20);
        chk("endrop busy after", busy, 0);
        goto(30);
        en = 1'b1;
        goto(42);
        chk("endrop den count", cnt_in(den_t, base, 0, 42), 3);
        chk("endrop den t1", at(den_t, n_den + 1) - base, 15);
        chk("endrop den t2 (counter held)", at(den_t, n_den + 2) - base, 40);
        if (den_a.size() > n_den + 2) begin
            chk("endrop den a1", den_a[n_den + 1], 7'h1e);
            chk("endrop den a2", den_a[n_den + 2], 7'h1f);
        end else begin
            chk("endrop den addr present", 0, 1);
        end
        chk("endrop sample count", cnt_in(sv_t, base, 0, 42), 2);

        // Reset during WAIT, then a stale ready strobe.
        start_run(4'b0001, 1'b0, 0, 16'h0000);
        goto(12);
        chk("rstwait busy", busy, 1);
        reset = 1'b1;
        goto(13);
        chk_all_zero("rstwait in reset");
        reset = 1'b0;
        goto(14);
        man_drdy = 1'b1;
        man_do   = 16'hDEAD;
        goto(15);
        man_drdy = 1'b0;
        chk_all_zero("rstwait late drdy");
        goto(18);
        chk("rstwait sample count", cnt_in(sv_t, base, 0, 18), 0);
        chk("rstwait den count", cnt_in(den_t, base, 0, 18), 1);

        // DRP ready never arrives.
        start_run(4'b0011, 1'b0, 0, 16'h0000);
        goto(18);
        chk("to busy in WAIT", busy, 1);
        chk("to not yet", timeout_err, 0);
`ifdef XADC_SEQ_TIMEOUT_EN
        goto(19);
        chk("to pulse", timeout_err, 1);
        chk("to no sample", sample_valid, 0);
        goto(20);
        chk("to next den", den_out, 1);
        chk("to next addr", daddr_out, 7'h1e);
        chk("to pulse width", timeout_err, 0);
`else
        goto(40);
        chk("to still waiting", busy, 1);
        chk("to den count", cnt_in(den_t, base, 0, 40), 1);
        chk("to err count", cnt_in(to_t, base, 0, 40), 0);
        chk("to addr held", daddr_out, 7'h1f);
        chk("to no sample", cnt_in(sv_t, base, 0, 40), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
